// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Tap-phase sequencer for a time-multiplexed serial FIR.
//                On a start strobe it walks phase 0..TAPS-1 once for each
//                of CHANNELS band channels, providing first/last-phase
//                strobes, a busy flag, a frame_done pulse and sticky
//                overrun detection.
//  Options     : PHASE_SEQUENCER_OVERRUN_EN - include overrun detection;
//                when undefined, overrun is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
  parameter int TAPS     = 64,
  parameter int CHANNELS = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     clk_enable,
  input  logic                                     start,
  output logic [$clog2(TAPS)-1:0]                  phase,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan,
  output logic                                     busy,
  output logic                                     phase_first,
  output logic                                     phase_last,
  output logic                                     control_phase_bar,
  output logic                                     frame_done,
  output logic                                     overrun
);

  localparam int PW = $clog2(TAPS);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [PW-1:0] c_last_phase = PW'(TAPS - 1);
  localparam logic [CW-1:0] c_last_chan  = CW'(CHANNELS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_phase, w_phase_next;
  logic [CW-1:0]   r_chan,  w_chan_next;
  logic            r_frame_done, w_frame_done_next;
  logic            w_phase_wrap;
  logic            w_final;

  // Phase wrap is an explicit compare so non-power-of-two tap counts work.
  assign w_phase_wrap = (r_phase == c_last_phase);
  assign w_final      = w_phase_wrap && (r_chan == c_last_chan);

  // Next-state logic; everything holds while clk_enable is low.
  always_comb begin
    w_state_next      = r_state;
    w_phase_next      = r_phase;
    w_chan_next       = r_chan;
    w_frame_done_next = r_frame_done;
    if (clk_enable) begin
      w_frame_done_next = 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_next = RUN;
            w_phase_next = '0;
            w_chan_next  = '0;
          end
        end
        RUN: begin
          if (w_phase_wrap) begin
            w_phase_next = '0;
            if (w_final) begin
              // End of frame: a start here is taken back-to-back.
              w_chan_next       = '0;
              w_frame_done_next = 1'b1;
              w_state_next      = start ? RUN : IDLE;
            end else begin
              w_chan_next = r_chan + 1'b1;
            end
          end else begin
            w_phase_next = r_phase + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_phase_next = '0;
          w_chan_next  = '0;
        end
      endcase
    end
  end

  // State, counters and frame_done register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_chan       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_chan       <= w_chan_next;
      r_frame_done <= w_frame_done_next;
    end
  end

`ifdef PHASE_SEQUENCER_OVERRUN_EN
  logic r_overrun;
  logic w_overrun_set;

  // A start that cannot be accepted is any enabled start in RUN except
  // on the final phase of the last channel.
  assign w_overrun_set = clk_enable && (r_state == RUN) && start && !w_final;

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign phase             = r_phase;
  assign chan              = r_chan;
  assign busy              = (r_state == RUN);
  assign frame_done        = r_frame_done;
  assign phase_first       = busy && clk_enable && (r_phase == '0);
  assign phase_last        = busy && clk_enable && w_phase_wrap;
  assign control_phase_bar = ~phase_last;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Self-checking bench for phase_sequencer. Three instances
//                (64x8, 5x3, 4x2) are exercised in turn with directed and
//                random stimulus against a frame-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic en_a [3];
  logic st_a [3];
  logic rs_a [3];

  wire [5:0] ph0;
  wire [2:0] ph1;
  wire [1:0] ph2;
  wire [2:0] ch0;
  wire [1:0] ch1;
  wire [0:0] ch2;
  wire [2:0] busy_w, first_w, last_w, cpb_w, done_w, ovr_w;

  phase_sequencer #(.TAPS(64), .CHANNELS(8)) u_dut0 (
    .clk(clk), .reset(rs_a[0]), .clk_enable(en_a[0]), .start(st_a[0]),
    .phase(ph0), .chan(ch0), .busy(busy_w[0]), .phase_first(first_w[0]),
    .phase_last(last_w[0]), .control_phase_bar(cpb_w[0]),
    .frame_done(done_w[0]), .overrun(ovr_w[0]));

  phase_sequencer #(.TAPS(5), .CHANNELS(3)) u_dut1 (
    .clk(clk), .reset(rs_a[1]), .clk_enable(en_a[1]), .start(st_a[1]),
    .phase(ph1), .chan(ch1), .busy(busy_w[1]), .phase_first(first_w[1]),
    .phase_last(last_w[1]), .control_phase_bar(cpb_w[1]),
    .frame_done(done_w[1]), .overrun(ovr_w[1]));

  phase_sequencer #(.TAPS(4), .CHANNELS(2)) u_dut2 (
    .clk(clk), .reset(rs_a[2]), .clk_enable(en_a[2]), .start(st_a[2]),
    .phase(ph2), .chan(ch2), .busy(busy_w[2]), .phase_first(first_w[2]),
    .phase_last(last_w[2]), .control_phase_bar(cpb_w[2]),
    .frame_done(done_w[2]), .overrun(ovr_w[2]));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a frame is a count of enabled RUN cycles (0..T*C-1).
  int taps_c  [3] = '{64, 5, 4};
  int chans_c [3] = '{8, 3, 2};
  int m_pos   [3];
  bit m_busy  [3];
  bit m_done  [3];
  bit m_ovr   [3];

  int o_phase, o_chan;
  bit o_busy, o_first, o_last, o_done, o_ovr;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, compare outputs with the model, then advance.
  task automatic step(input int idx, input bit e, input bit s, input bit r);
    int t, c, last, exp_ph, exp_ch;
    bit ef, el, nd;
    en_a[idx] = e;
    st_a[idx] = s;
    rs_a[idx] = r;
    #1;
    case (idx)
      0:       begin o_phase = int'(ph0); o_chan = int'(ch0); end
      1:       begin o_phase = int'(ph1); o_chan = int'(ch1); end
      default: begin o_phase = int'(ph2); o_chan = int'(ch2); end
    endcase
    o_busy  = busy_w[idx];
    o_first = first_w[idx];
    o_last  = last_w[idx];
    o_done  = done_w[idx];
    o_ovr   = ovr_w[idx];

    t      = taps_c[idx];
    c      = chans_c[idx];
    last   = t * c - 1;
    exp_ph = m_busy[idx] ? (m_pos[idx] % t) : 0;
    exp_ch = m_busy[idx] ? (m_pos[idx] / t) : 0;
    ef     = m_busy[idx] && e && (exp_ph == 0);
    el     = m_busy[idx] && e && (exp_ph == t - 1);

    check_value($sformatf("u%0d.phase", idx), o_phase, exp_ph);
    check_value($sformatf("u%0d.chan", idx), o_chan, exp_ch);
    check_value($sformatf("u%0d.busy", idx), {31'd0, busy_w[idx]}, {31'd0, m_busy[idx]});
    check_value($sformatf("u%0d.phase_first", idx), {31'd0, first_w[idx]}, {31'd0, ef});
    check_value($sformatf("u%0d.phase_last", idx), {31'd0, last_w[idx]}, {31'd0, el});
    check_value($sformatf("u%0d.control_phase_bar", idx), {31'd0, cpb_w[idx]}, {31'd0, !el});
    check_value($sformatf("u%0d.frame_done", idx), {31'd0, done_w[idx]}, {31'd0, m_done[idx]});
    check_value($sformatf("u%0d.overrun", idx), {31'd0, ovr_w[idx]}, {31'd0, m_ovr[idx]});

    if (r) begin
      m_busy[idx] = 1'b0;
      m_pos[idx]  = 0;
      m_done[idx] = 1'b0;
      m_ovr[idx]  = 1'b0;
    end else if (e) begin
      nd = m_busy[idx] && (m_pos[idx] == last);
      if (m_busy[idx]) begin
        if (m_pos[idx] == last) begin
          m_busy[idx] = s;
          m_pos[idx]  = 0;
        end else begin
`ifdef PHASE_SEQUENCER_OVERRUN_EN
          if (s) m_ovr[idx] = 1'b1;
`endif
          m_pos[idx] = m_pos[idx] + 1;
        end
      end else if (s) begin
        m_busy[idx] = 1'b1;
        m_pos[idx]  = 0;
      end
      m_done[idx] = nd;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic park(input int idx);
    en_a[idx] = 1'b0;
    st_a[idx] = 1'b0;
    rs_a[idx] = 1'b0;
  endtask

  int bc, fc, lc, dc, dcyc;
  bit exp_ovr;

  // Directed scenarios followed by randomized traffic on each instance.
  initial begin
    for (int i = 0; i < 3; i++) begin
      en_a[i] = 1'b0; st_a[i] = 1'b0; rs_a[i] = 1'b1;
      m_pos[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rs_a[i] = 1'b0;

    // ---- 64 x 8: reset state and idle ----
    for (int i = 0; i < 100; i++) step(0, 1'b1, 1'b0, 1'b0);

    // ---- single frame ----
    step(0, 1'b1, 1'b1, 1'b0);
    bc = 0; fc = 0; lc = 0; dc = 0; dcyc = -1;
    for (int i = 1; i <= 520; i++) begin
      step(0, 1'b1, 1'b0, 1'b0);
      bc += int'(o_busy);
      fc += int'(o_first);
      lc += int'(o_last);
      if (o_done) begin dc++; dcyc = i; end
    end
    check_value("u0.busy_cycles", bc, 512);
    check_value("u0.first_count", fc, 8);
    check_value("u0.last_count", lc, 8);
    check_value("u0.done_count", dc, 1);
    check_value("u0.done_cycle", dcyc, 513);

    // ---- reset mid-frame at phase 30, chan 4 ----
    step(0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 286; i++) step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b1);
    check_value("u0.pre_reset_phase", o_phase, 30);
    check_value("u0.pre_reset_chan", o_chan, 4);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0);

    // ---- clk_enable toggling through a whole frame ----
    step(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 1040; i++) step(0, (i % 2) == 0, 1'b0, 1'b0);

    // ---- clk_enable dropped on the final phase ----
    step(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 511; i++) step(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    check_value("u0.done_held", {31'd0, o_done}, 32'd1);
    step(0, 1'b1, 1'b0, 1'b0);
    check_value("u0.done_single", {31'd0, o_done}, 32'd0);

    // ---- random traffic ----
    for (int i = 0; i < 2000; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 499) == 0);
    park(0);

    // ---- 5 x 3: non-power-of-two taps ----
    step(1, 1'b1, 1'b1, 1'b0);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1'b1, 1'b0, 1'b0);
      bc += int'(o_busy);
      if (o_phase > 4) check_value("u1.phase_range", o_phase, 4);
    end
    check_value("u1.busy_cycles", bc, 15);
    for (int i = 0; i < 400; i++)
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 199) == 0);
    park(1);

    // ---- 4 x 2: overrun and back-to-back ----
`ifdef PHASE_SEQUENCER_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    step(2, 1'b1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    check_value("u2.overrun_after_early_start", {31'd0, o_ovr}, {31'd0, exp_ovr});
    check_value("u2.phase_unchanged", o_phase, 3);
    step(2, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 1'b0);
    check_value("u2.final_phase", o_phase, 3);
    check_value("u2.final_chan", o_chan, 1);
    step(2, 1'b1, 1'b0, 1'b0);
    check_value("u2.b2b_busy", {31'd0, o_busy}, 32'd1);
    check_value("u2.b2b_done", {31'd0, o_done}, 32'd1);
    check_value("u2.b2b_first", {31'd0, o_first}, 32'd1);
    for (int i = 0; i < 500; i++)
      step(2, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 149) == 0);
    park(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
